ro_freq_counter: RTL and testbench
==================================

Name: ro_freq_counter

Overview:
Measurement controller that sits directly downstream of the gated ring oscillator. It drives the oscillator's enable, lets it settle, then counts oscillator rising edges over a programmable number of system-clock cycles. It presents a saturating count with done/overflow flags to the register or IO logic. Edges are counted in the system-clock domain after synchronisation, so the oscillator frequency being measured must be below f_clk/2.

Parameters:
CNT_W, 16, width of the edge counter and the count output
WIN_W, 16, width of the gate-window length input
SETTLE_CYCLES, 4, clk cycles with ro_en high before counting starts (minimum 1)
SYNC_STAGES, 2, flip-flop stages synchronising ro_out into clk (minimum 2)

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request a measurement; sampled only in IDLE
window  in  WIN_W  gate length in clk cycles; captured on the accepted start
ro_out  in  1  ring oscillator output; asynchronous to clk
ro_en  out  1  enable to the ring oscillator; high only in SETTLE and MEASURE
busy  out  1  high in SETTLE and MEASURE
done  out  1  one-cycle pulse when the result is valid
count  out  CNT_W  rising edges counted in the last window; held until next accepted start
overflow  out  1  sticky; set if the count saturated in the last window

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (asynchronous, any state): state=IDLE, ro_en=0, busy=0, done=0, count=0, overflow=0, synchroniser and edge-history flops=0.
  - ro_en falls immediately on reset, not at the next clock edge.
- Synchroniser: ro_out passes through SYNC_STAGES flops, then one history flop.
  - edge = sync_q & ~hist_q.
  - These flops run in every state.
- States: IDLE, SETTLE, MEASURE, DONE.
- IDLE:
  - If start=1: capture window into win_q, clear count and overflow, load settle counter, go to SETTLE.
  - Otherwise stay in IDLE.
- SETTLE:
  - ro_en=1, busy=1.
  - Lasts exactly SETTLE_CYCLES cycles.
  - Edges are ignored.
  - Then go to MEASURE, or to DONE if win_q==0.
- MEASURE:
  - ro_en=1, busy=1.
  - Lasts exactly win_q cycles.
  - Each cycle with edge=1 increments count.
  - At all-ones, count holds and overflow is set; count never wraps.
  - After the last cycle, go to DONE.
- DONE:
  - Lasts one cycle: done=1, ro_en=0, busy=0.
  - Then go to IDLE.
- Timing (start sampled at edge E0):
  - ro_en is high from E0 up to E0+SETTLE_CYCLES+win_q.
  - done is high in the cycle following edge E0+SETTLE_CYCLES+win_q.
- start handling:
  - Ignored while busy or in DONE; it is not queued.
  - A start held high continuously retriggers from IDLE (one cycle after done).
- window is sampled only on the accepted start; later changes do not affect the measurement in progress.
- count and overflow are stable outside MEASURE.
  - They change only on an accepted start (cleared) or during MEASURE.
- Reset during SETTLE or MEASURE aborts the measurement: no done pulse, count=0.

Test Plan:
- Reset mid-MEASURE: assert rst asynchronously between clock edges -> ro_en, busy, done, count, overflow all 0 before the next clk edge; no done afterwards; a new start works normally.
- Nominal: ro_out square wave of period 4 clk (2 high/2 low); window=100, SETTLE_CYCLES=4; start pulse -> ro_en high for exactly 104 cycles, busy matches, done single pulse at E0+105, count=25, overflow=0.
- Saturation (CNT_W=4): ro_out period 2 clk, window=40 -> count=15, overflow=1; next start with window=10 -> overflow cleared, count=5.
- Zero window: window=0 -> ro_en high exactly SETTLE_CYCLES cycles, done pulse, count=0; ro_out held constant 1 with window=50 -> count=0.
- Start while busy / window change: second start pulse and window change to 7 during MEASURE of window=100 -> both ignored, single done, count=25; start held high -> back-to-back measurements, each with its own done pulse.

Source files
------------

// File: rtl/ro_freq_counter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ro_freq_counter: gated ring-oscillator edge counter over a clk window  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module ro_freq_counter #(
   parameter int CNT_W         = 16,
   parameter int WIN_W         = 16,
   parameter int SETTLE_CYCLES = 4,
   parameter int SYNC_STAGES   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIN_W-1:0] window,
   input  logic             ro_out,
   output logic             ro_en,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);

   localparam int c_SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [c_SET_W-1:0] c_SET_LOAD = c_SET_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_MEASURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                 r_hist;
   logic                 w_edge;
   logic [c_SET_W-1:0]   r_settle;
   logic [WIN_W-1:0]     r_win;
   logic [CNT_W-1:0]     r_count;
   logic                 r_overflow;

   // Synchroniser and edge history run continuously, independent of state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], ro_out};
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_edge = r_sync[SYNC_STAGES-1] & ~r_hist;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = S_SETTLE;
         end
         S_SETTLE: begin
            if (r_settle == '0) w_next = (r_win == '0) ? S_DONE : S_MEASURE;
         end
         S_MEASURE: begin
            if (r_win == WIN_W'(1)) w_next = S_DONE;
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // r_win holds the captured window and counts down the remaining MEASURE cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_settle   <= '0;
         r_win      <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_win      <= window;
                  r_settle   <= c_SET_LOAD;
                  r_count    <= '0;
                  r_overflow <= 1'b0;
               end
            end
            S_SETTLE: begin
               if (r_settle != '0) r_settle <= r_settle - c_SET_W'(1);
            end
            S_MEASURE: begin
               r_win <= r_win - WIN_W'(1);
               if (w_edge) begin
                  if (&r_count) r_overflow <= 1'b1;
                  else          r_count    <= r_count + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Decoded straight from the state register so reset drops ro_en immediately.
   assign ro_en    = (r_state == S_SETTLE) || (r_state == S_MEASURE);
   assign busy     = ro_en;
   assign done     = (r_state == S_DONE);
   assign count    = r_count;
   assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ro_freq_counter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_ro_freq_counter: randomized self-checking bench for ro_freq_counter |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_ro_freq_counter;

   localparam int S    = 4;
   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] window;
   logic        ro_out = 1'b0;
   logic        ro_en, busy, done, overflow;
   logic [15:0] count;
   logic        ro_en4, busy4, done4, ovf4;
   logic [3:0]  count4;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic ro_hist [0:32767];

   int ro_mode = 0;
   logic ro_level = 1'b0;
   int ro_per = 4;
   int ro_hi = 2;
   int ro_ph = 0;

   ro_freq_counter dut (
      .clk(clk), .rst(rst), .start(start), .window(window), .ro_out(ro_out),
      .ro_en(ro_en), .busy(busy), .done(done), .count(count), .overflow(overflow)
   );

   ro_freq_counter #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .window(window), .ro_out(ro_out),
      .ro_en(ro_en4), .busy(busy4), .done(done4), .count(count4), .overflow(ovf4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cyc < 32768) ro_hist[cyc] <= ro_out;
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      case (ro_mode)
         0: ro_out = ro_level;
         1: begin
            ro_out = (ro_ph < ro_hi);
            ro_ph  = (ro_ph + 1 >= ro_per) ? 0 : ro_ph + 1;
         end
         default: ro_out = 1'($urandom_range(0, 1));
      endcase
   end

   // Edges seen by the counter are the sampled oscillator delayed by the synchroniser.
   function automatic int model_edges(input int e0, input int w);
      int n = 0;
      for (int j = e0 + S + 1; j <= e0 + S + w; j++)
         if (ro_hist[j-SYNC] && !ro_hist[j-SYNC-1]) n++;
      return n;
   endfunction

   task automatic run_meas(input int w, input bit hold, input bit poke, input bit chained,
                           input string tag, output int edges);
      int e0, en_cnt, done_n, bad, exp16, exp4;
      @(negedge clk);
      if (!chained) begin
         window = w[15:0];
         start  = 1'b1;
      end
      e0 = cyc;
      en_cnt = 0; done_n = 0; bad = 0;
      for (int i = 1; i <= 2000; i++) begin
         @(negedge clk);
         if (i == 1 && !hold) start = 1'b0;
         if (poke && i == S + 10) begin start = 1'b1; window = 16'd7; end
         if (poke && i == S + 11) start = 1'b0;
         if (ro_en) en_cnt++;
         if (busy !== ro_en || busy4 !== ro_en4 || ro_en4 !== ro_en || done4 !== done) bad++;
         if (done === 1'b1) begin done_n = i; break; end
      end
      edges = model_edges(e0, w);
      exp16 = (edges > 65535) ? 65535 : edges;
      exp4  = (edges > 15) ? 15 : edges;
      checks++;
      if (done_n != S + w + 1)
         $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_n, S + w + 1);
      if (done_n != S + w + 1) errors++;
      checks++;
      if (en_cnt != S + w) begin
         $display("FAIL %s ro_en_cycles: got %0d expected %0d", tag, en_cnt, S + w);
         errors++;
      end
      checks++;
      if (bad != 0) begin
         $display("FAIL %s busy_ro_en_match: got %0d bad cycles expected 0", tag, bad);
         errors++;
      end
      checks++;
      if (count !== exp16[15:0] || overflow !== 1'(edges > 65535)) begin
         $display("FAIL %s count16: got %0d/%b expected %0d/%b", tag, count, overflow,
                  exp16, 1'(edges > 65535));
         errors++;
      end
      checks++;
      if (count4 !== exp4[3:0] || ovf4 !== 1'(edges > 15)) begin
         $display("FAIL %s count4: got %0d/%b expected %0d/%b", tag, count4, ovf4,
                  exp4, 1'(edges > 15));
         errors++;
      end
      if (!hold) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || ro_en !== 1'b0 || count !== exp16[15:0] || count4 !== exp4[3:0]) begin
            $display("FAIL %s after_done: got done=%b ro_en=%b count=%0d expected 0 0 %0d",
                     tag, done, ro_en, count, exp16);
            errors++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; window = '0;
      #3;
      checks++;
      if ({ro_en, busy, done, count, overflow, ro_en4, busy4, done4, count4, ovf4} !== '0) begin
         $display("FAIL reset_state: got %b expected all zero",
                  {ro_en, busy, done, count, overflow, ro_en4, busy4, done4, count4, ovf4});
         errors++;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_nominal();
      int e;
      ro_mode = 1; ro_per = 4; ro_hi = 2;
      run_meas(100, 0, 0, 0, "nominal", e);
      checks++;
      if (count !== 16'd25 || overflow !== 1'b0) begin
         $display("FAIL nominal_const: got %0d/%b expected 25/0", count, overflow);
         errors++;
      end
   endtask

   task automatic test_saturation();
      int e;
      ro_mode = 1; ro_per = 2; ro_hi = 1;
      run_meas(40, 0, 0, 0, "sat40", e);
      checks++;
      if (count4 !== 4'd15 || ovf4 !== 1'b1) begin
         $display("FAIL sat_const: got %0d/%b expected 15/1", count4, ovf4);
         errors++;
      end
      run_meas(10, 0, 0, 0, "sat10", e);
      checks++;
      if (count4 !== 4'd5 || ovf4 !== 1'b0) begin
         $display("FAIL sat_clear: got %0d/%b expected 5/0", count4, ovf4);
         errors++;
      end
   endtask

   task automatic test_zero_window();
      int e;
      run_meas(0, 0, 0, 0, "zero_win", e);
      ro_mode = 0; ro_level = 1'b1;
      repeat (5) @(negedge clk);
      run_meas(50, 0, 0, 0, "const_high", e);
      checks++;
      if (count !== 16'd0) begin
         $display("FAIL const_high_zero: got %0d expected 0", count);
         errors++;
      end
   endtask

   task automatic test_busy_start();
      int e;
      ro_mode = 1; ro_per = 4; ro_hi = 2;
      run_meas(100, 0, 1, 0, "busy_poke", e);
      checks++;
      if (count !== 16'd25) begin
         $display("FAIL busy_poke_count: got %0d expected 25", count);
         errors++;
      end
   endtask

   task automatic test_back_to_back();
      int e;
      ro_mode = 2;
      run_meas(30, 1, 0, 0, "b2b_first", e);
      run_meas(30, 1, 0, 1, "b2b_second", e);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL b2b_stop: got done=%b busy=%b expected 0 0", done, busy);
         errors++;
      end
   endtask

   task automatic test_reset_mid();
      int e, spurious;
      ro_mode = 1; ro_per = 4; ro_hi = 2;
      @(negedge clk);
      window = 16'd100; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (S + 30) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({ro_en, busy, done, count, overflow, ro_en4, count4, ovf4} !== '0) begin
         $display("FAIL reset_mid: got %b expected all zero",
                  {ro_en, busy, done, count, overflow, ro_en4, count4, ovf4});
         errors++;
      end
      @(negedge clk);
      rst = 1'b0;
      spurious = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || ro_en !== 1'b0) spurious++;
      end
      checks++;
      if (spurious != 0) begin
         $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", spurious);
         errors++;
      end
      run_meas(100, 0, 0, 0, "after_reset", e);
   endtask

   task automatic test_random();
      int e, w;
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) begin
            ro_mode = 2;
         end else begin
            ro_mode = 1;
            ro_per  = $urandom_range(2, 9);
            ro_hi   = $urandom_range(1, ro_per - 1);
            ro_ph   = 0;
         end
         w = $urandom_range(0, 300);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_meas(w, 0, 0, 0, "random", e);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_saturation();
      test_zero_window();
      test_busy_start();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
